swg_loop_ctrl_dyn: RTL and testbench

Runtime-programmable N-level loop controller for the sliding-window generator datapath. It replaces compile-time loop bounds and address increments with a configuration handshake, and emits one increment beat per innermost iteration over a valid/ready stream. A pending-config slot allows frames with different geometry to run back-to-back without a bubble. It sits between the host configuration path and the cyclic-buffer read/write address logic.

---
 rtl/swg_loop_ctrl_dyn.sv | 203 ++++++++++++++++++++
 tb/tb_swg_loop_ctrl_dyn.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/swg_loop_ctrl_dyn.sv
// rtl/swg_loop_ctrl_dyn.sv - runtime-programmable N-level loop controller for the sliding-window generator
// Optional feature: SWG_CTRL_AUTORESTART_EN (repeat the active frame when no config is pending)
module swg_loop_ctrl_dyn #(
    parameter int NUM_LOOPS  = 5,
    parameter int CNT_WIDTH  = 16,
    parameter int INCR_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    input  logic [NUM_LOOPS*CNT_WIDTH-1:0]    cfg_iter,
    input  logic [NUM_LOOPS*INCR_WIDTH-1:0]   cfg_head_incr,
    input  logic [(NUM_LOOPS+1)*INCR_WIDTH-1:0] cfg_tail_incr,
    output logic                              incr_valid,
    input  logic                              incr_ready,
    output logic [INCR_WIDTH-1:0]             head_incr,
    output logic [INCR_WIDTH-1:0]             tail_incr,
    output logic                              last,
    output logic                              busy
);

    localparam int KW = (NUM_LOOPS > 1) ? $clog2(NUM_LOOPS) : 1;
    localparam int IW = NUM_LOOPS * CNT_WIDTH;
    localparam int HW = NUM_LOOPS * INCR_WIDTH;
    localparam int TW = (NUM_LOOPS + 1) * INCR_WIDTH;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                pend_full_q, pend_full_d;
    logic [IW-1:0]       pend_iter_q, pend_iter_d;
    logic [HW-1:0]       pend_head_q, pend_head_d;
    logic [TW-1:0]       pend_tail_q, pend_tail_d;
    logic [IW-1:0]       act_iter_q, act_iter_d;
    logic [HW-1:0]       act_head_q, act_head_d;
    logic [TW-1:0]       act_tail_q, act_tail_d;
    logic [CNT_WIDTH-1:0] cnt_q [NUM_LOOPS];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_LOOPS];
    logic                first_q, first_d;
    logic [KW-1:0]       kprev_q, kprev_d;

    logic                run;
    logic                cfg_fire;
    logic                any_nz;
    logic [KW-1:0]       j_sel;
    logic [INCR_WIDTH-1:0] head_sel;
    logic [INCR_WIDTH-1:0] tail_sel;
    logic                load_pend;
    logic                restart;

    assign run       = (state_q == S_RUN);
    assign cfg_ready = !pend_full_q;
    assign cfg_fire  = cfg_valid && !pend_full_q;

    // Lowest non-zero counter is the loop that advances on this beat.
    always_comb begin
        any_nz = 1'b0;
        j_sel  = '0;
        for (int k = NUM_LOOPS - 1; k >= 0; k--) begin
            if (cnt_q[k] != '0) begin
                any_nz = 1'b1;
                j_sel  = KW'(k);
            end
        end
    end

    always_comb begin
        head_sel = '0;
        for (int k = 0; k < NUM_LOOPS; k++) begin
            if (kprev_q == KW'(k)) begin
                head_sel = act_head_q[k*INCR_WIDTH +: INCR_WIDTH];
            end
        end
        tail_sel = act_tail_q[NUM_LOOPS*INCR_WIDTH +: INCR_WIDTH];
        if (any_nz) begin
            for (int k = 0; k < NUM_LOOPS; k++) begin
                if (j_sel == KW'(k)) begin
                    tail_sel = act_tail_q[k*INCR_WIDTH +: INCR_WIDTH];
                end
            end
        end
    end

    assign incr_valid = run;
    assign head_incr  = (run && !first_q) ? head_sel : '0;
    assign tail_incr  = run ? tail_sel : '0;
    assign last       = run && !any_nz;
    assign busy       = run;

    always_comb begin
        state_d     = state_q;
        pend_full_d = pend_full_q;
        pend_iter_d = pend_iter_q;
        pend_head_d = pend_head_q;
        pend_tail_d = pend_tail_q;
        act_iter_d  = act_iter_q;
        act_head_d  = act_head_q;
        act_tail_d  = act_tail_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        kprev_d     = kprev_q;
        load_pend   = 1'b0;
        restart     = 1'b0;

        if (cfg_fire) begin
            pend_full_d = 1'b1;
            pend_iter_d = cfg_iter;
            pend_head_d = cfg_head_incr;
            pend_tail_d = cfg_tail_incr;
        end

        case (state_q)
            S_IDLE: begin
                if (pend_full_q) begin
                    load_pend = 1'b1;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (incr_ready) begin
                    if (any_nz) begin
                        for (int k = 0; k < NUM_LOOPS; k++) begin
                            if (KW'(k) == j_sel) begin
                                cnt_d[k] = cnt_q[k] - CNT_WIDTH'(1);
                            end else if (KW'(k) < j_sel) begin
                                cnt_d[k] = act_iter_q[k*CNT_WIDTH +: CNT_WIDTH];
                            end
                        end
                        kprev_d = j_sel;
                        first_d = 1'b0;
                    end else if (pend_full_q) begin
                        // Only a config already registered chains without a bubble.
                        load_pend = 1'b1;
                    end else begin
`ifdef SWG_CTRL_AUTORESTART_EN
                        restart = 1'b1;
`else
                        state_d = S_IDLE;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load_pend) begin
            act_iter_d  = pend_iter_q;
            act_head_d  = pend_head_q;
            act_tail_d  = pend_tail_q;
            pend_full_d = 1'b0;
            first_d     = 1'b1;
            kprev_d     = '0;
            for (int k = 0; k < NUM_LOOPS; k++) begin
                cnt_d[k] = pend_iter_q[k*CNT_WIDTH +: CNT_WIDTH];
            end
        end

        if (restart) begin
            first_d = 1'b1;
            kprev_d = '0;
            for (int k = 0; k < NUM_LOOPS; k++) begin
                cnt_d[k] = act_iter_q[k*CNT_WIDTH +: CNT_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pend_full_q <= 1'b0;
            pend_iter_q <= '0;
            pend_head_q <= '0;
            pend_tail_q <= '0;
            act_iter_q  <= '0;
            act_head_q  <= '0;
            act_tail_q  <= '0;
            first_q     <= 1'b0;
            kprev_q     <= '0;
            for (int k = 0; k < NUM_LOOPS; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pend_full_q <= pend_full_d;
            pend_iter_q <= pend_iter_d;
            pend_head_q <= pend_head_d;
            pend_tail_q <= pend_tail_d;
            act_iter_q  <= act_iter_d;
            act_head_q  <= act_head_d;
            act_tail_q  <= act_tail_d;
            first_q     <= first_d;
            kprev_q     <= kprev_d;
            for (int k = 0; k < NUM_LOOPS; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

endmodule

// File: tb/tb_swg_loop_ctrl_dyn.sv
// tb/tb_swg_loop_ctrl_dyn.sv - directed-vector bench for swg_loop_ctrl_dyn (3 loops)
module tb_swg_loop_ctrl_dyn;

    localparam int NL = 3;
    localparam int CW = 16;
    localparam int IW = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [NL*CW-1:0]     cfg_iter;
    logic [NL*IW-1:0]     cfg_head_incr;
    logic [(NL+1)*IW-1:0] cfg_tail_incr;
    logic                 incr_valid;
    logic                 incr_ready;
    logic [IW-1:0]        head_incr;
    logic [IW-1:0]        tail_incr;
    logic                 last;
    logic                 busy;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_head[$];
    logic [15:0] exp_tail[$];
    logic        exp_last[$];

    localparam logic [NL*CW-1:0]     ITER_A = {16'd0, 16'd2, 16'd1};
    localparam logic [NL*CW-1:0]     ITER_Z = {16'd0, 16'd0, 16'd0};
    localparam logic [NL*IW-1:0]     HEAD_A = {16'd100, 16'd10, 16'd1};
    localparam logic [(NL+1)*IW-1:0] TAIL_A = {16'd7, 16'd200, 16'd20, 16'd2};
    localparam logic [(NL+1)*IW-1:0] TAIL_B = {16'd5, 16'd200, 16'd20, 16'd2};

    swg_loop_ctrl_dyn #(.NUM_LOOPS(NL), .CNT_WIDTH(CW), .INCR_WIDTH(IW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_iter      (cfg_iter),
        .cfg_head_incr (cfg_head_incr),
        .cfg_tail_incr (cfg_tail_incr),
        .incr_valid    (incr_valid),
        .incr_ready    (incr_ready),
        .head_incr     (head_incr),
        .tail_incr     (tail_incr),
        .last          (last),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        cfg_valid  = 1'b0;
        incr_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_cfg(input logic [NL*CW-1:0] it, input logic [(NL+1)*IW-1:0] tl);
        int n = 0;
        @(negedge clk);
        cfg_valid     = 1'b1;
        cfg_iter      = it;
        cfg_head_incr = HEAD_A;
        cfg_tail_incr = tl;
        while (!cfg_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("cfg_timeout", 32'(n), 32'd0);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic push_a();
        exp_head.push_back(16'd0);  exp_tail.push_back(16'd2);  exp_last.push_back(1'b0);
        exp_head.push_back(16'd1);  exp_tail.push_back(16'd20); exp_last.push_back(1'b0);
        exp_head.push_back(16'd10); exp_tail.push_back(16'd2);  exp_last.push_back(1'b0);
        exp_head.push_back(16'd1);  exp_tail.push_back(16'd20); exp_last.push_back(1'b0);
        exp_head.push_back(16'd10); exp_tail.push_back(16'd2);  exp_last.push_back(1'b0);
        exp_head.push_back(16'd1);  exp_tail.push_back(16'd7);  exp_last.push_back(1'b1);
    endtask

    task automatic clear_exp();
        exp_head.delete();
        exp_tail.delete();
        exp_last.delete();
    endtask

    // Every valid cycle (including stalls) must show the fields of the current expected beat.
    task automatic run_check(input string name, input bit toggle, output int span, output int gaps);
        int bi = 0;
        int cyc = 0;
        int first = -1;
        bit rdy;
        gaps = 0;
        while (bi < exp_head.size() && cyc < 200) begin
            @(negedge clk);
            rdy = toggle ? (cyc % 2 == 0) : 1'b1;
            incr_ready = rdy;
            if (incr_valid) begin
                if (first < 0) first = cyc;
                check($sformatf("%s_head%0d", name, bi), 32'(head_incr), 32'(exp_head[bi]));
                check($sformatf("%s_tail%0d", name, bi), 32'(tail_incr), 32'(exp_tail[bi]));
                check($sformatf("%s_last%0d", name, bi), 32'(last), 32'(exp_last[bi]));
                if (rdy) bi++;
            end else if (first >= 0) begin
                gaps++;
            end
            cyc++;
        end
        if (bi < exp_head.size()) check($sformatf("%s_timeout", name), 32'(bi), 32'(exp_head.size()));
        span = (first < 0) ? 0 : cyc - first;
    endtask

    initial begin
        int span;
        int gaps;
        int seen;
        cfg_valid     = 1'b0;
        cfg_iter      = '0;
        cfg_head_incr = '0;
        cfg_tail_incr = '0;
        incr_ready    = 1'b0;
        rst_n         = 1'b0;

        do_reset();
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rst_valid", 32'(incr_valid), 32'd0);
        check("rst_head", 32'(head_incr), 32'd0);
        check("rst_tail", 32'(tail_incr), 32'd0);
        check("rst_last", 32'(last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Frame A with ready held high.
        clear_exp(); push_a();
        send_cfg(ITER_A, TAIL_A);
        run_check("t1", 1'b0, span, gaps);
        check("t1_span", 32'(span), 32'd6);
        check("t1_gaps", 32'(gaps), 32'd0);
        @(negedge clk);
`ifdef SWG_CTRL_AUTORESTART_EN
        check("t1_restart_valid", 32'(incr_valid), 32'd1);
        check("t1_restart_head", 32'(head_incr), 32'd0);
        check("t1_restart_busy", 32'(busy), 32'd1);
`else
        check("t1_idle_valid", 32'(incr_valid), 32'd0);
        check("t1_idle_busy", 32'(busy), 32'd0);
`endif

        // Frame A with ready toggling.
        do_reset();
        send_cfg(ITER_A, TAIL_A);
        run_check("t2", 1'b1, span, gaps);
        check("t2_span", 32'(span), 32'd11);

        // Two queued configs: seven back-to-back beats.
        do_reset();
        clear_exp(); push_a();
        exp_head.push_back(16'd0); exp_tail.push_back(16'd5); exp_last.push_back(1'b1);
        send_cfg(ITER_A, TAIL_A);
        send_cfg(ITER_Z, TAIL_B);
        run_check("t3", 1'b0, span, gaps);
        check("t3_span", 32'(span), 32'd7);
        check("t3_gaps", 32'(gaps), 32'd0);

        // Single-iteration frame, plus config-accept to first-beat latency.
        do_reset();
        send_cfg(ITER_Z, TAIL_A);
        check("t4_lat_early", 32'(incr_valid), 32'd0);
        clear_exp();
        exp_head.push_back(16'd0); exp_tail.push_back(16'd7); exp_last.push_back(1'b1);
        run_check("t4", 1'b0, span, gaps);
        check("t4_span", 32'(span), 32'd1);

        // Config accepted on the last-beat edge with pending empty: one bubble.
        do_reset();
        send_cfg(ITER_Z, TAIL_A);
        @(negedge clk);
        check("t5_single_last", 32'(last), 32'd1);
        incr_ready    = 1'b1;
        cfg_valid     = 1'b1;
        cfg_iter      = ITER_Z;
        cfg_tail_incr = TAIL_B;
        @(negedge clk);
        cfg_valid = 1'b0;
`ifndef SWG_CTRL_AUTORESTART_EN
        check("t5_bubble", 32'(incr_valid), 32'd0);
        @(negedge clk);
`endif
        check("t5_next_valid", 32'(incr_valid), 32'd1);
        check("t5_next_tail", 32'(tail_incr), 32'd5);
        check("t5_next_head", 32'(head_incr), 32'd0);

        // Reset mid-frame with a pending config.
        do_reset();
        send_cfg(ITER_A, TAIL_A);
        send_cfg(ITER_Z, TAIL_B);
        check("t6_pending", 32'(cfg_ready), 32'd0);
        @(negedge clk);
        incr_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_beat3_tail", 32'(tail_incr), 32'd2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t6_rst_valid", 32'(incr_valid), 32'd0);
        check("t6_rst_head", 32'(head_incr), 32'd0);
        check("t6_rst_tail", 32'(tail_incr), 32'd0);
        check("t6_rst_last", 32'(last), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_cfg_ready", 32'(cfg_ready), 32'd1);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (incr_valid) seen++;
        end
        check("t6_no_beats", 32'(seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
